// File: rtl/game_strobe_timer_if.sv
// Control/status bundle between the game logic and the strobe-driven countdown timer.
// The master side drives the controls; the timer itself sits on the slave side.
interface game_strobe_timer_if #(
  parameter int width = 8
);
  logic             strobe;
  logic             start;
  logic [width-1:0] period;
  logic             pause;
  logic             abort;
  logic             repeat_en;
  logic [width-1:0] count;
  logic             running;
  logic             paused;
  logic             expired;

  modport master (
    output strobe, start, period, pause, abort, repeat_en,
    input  count, running, paused, expired
  );

  modport slave (
    input  strobe, start, period, pause, abort, repeat_en,
    output count, running, paused, expired
  );
endinterface

// File: rtl/game_strobe_timer.sv
// Strobe-counting countdown timer with pause, abort and auto-repeat.
// Every output is a register; priority each cycle is abort > start > pause > strobe.
module game_strobe_timer #(
  parameter int width = 8
) (
  input  logic                clk,
  input  logic                rst,
  game_strobe_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [width-1:0] count_one = {{(width-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [width-1:0] r_count;
  logic [width-1:0] r_period_q;
  logic             r_running;
  logic             r_paused;
  logic             r_expired;

  logic             w_count_is_one;
  logic             w_period_zero;

  assign w_count_is_one = (r_count == count_one);
  assign w_period_zero  = (bus.period == '0);

  // NOTE: every register here is small and flop-based, so all of it is reset
  // asynchronously; reset must kill a pending expiry immediately.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below sees the pre-edge values of r_count and r_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_period_q <= '0;
      r_running  <= 1'b0;
      r_paused   <= 1'b0;
      r_expired  <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (bus.abort) begin
        r_state   <= ST_IDLE;
        r_count   <= '0;
        r_running <= 1'b0;
        r_paused  <= 1'b0;
      end else if (bus.start) begin
        // A zero-length start expires at once and never arms, even with repeat.
        if (w_period_zero) begin
          r_state   <= ST_IDLE;
          r_count   <= '0;
          r_expired <= 1'b1;
          r_running <= 1'b0;
          r_paused  <= 1'b0;
        end else begin
          r_state    <= ST_RUN;
          r_count    <= bus.period;
          r_period_q <= bus.period;
          r_running  <= 1'b1;
          r_paused   <= 1'b0;
        end
      end else begin
        case (r_state)
          ST_RUN: begin
            if (bus.pause) begin
              r_state  <= ST_PAUSE;
              r_paused <= 1'b1;
            end else if (bus.strobe) begin
              if (w_count_is_one) begin
                r_expired <= 1'b1;
                if (bus.repeat_en) begin
                  r_count <= r_period_q;
                end else begin
                  r_state   <= ST_IDLE;
                  r_count   <= '0;
                  r_running <= 1'b0;
                end
              end else begin
                r_count <= r_count - count_one;
              end
            end
          end
          ST_PAUSE: begin
            // Leaving pause swallows any strobe that arrives on the same edge.
            if (!bus.pause) begin
              r_state  <= ST_RUN;
              r_paused <= 1'b0;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.count   = r_count;
  assign bus.running = r_running;
  assign bus.paused  = r_paused;
  assign bus.expired = r_expired;

endmodule

// File: tb/tb_game_strobe_timer.sv
// Directed-vector bench for game_strobe_timer; expected values are hand-computed.
module tb_game_strobe_timer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  game_strobe_timer_if #(.width(8)) bus ();

  game_strobe_timer #(.width(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given strobe level; sampling happens 1ns after the edge.
  task automatic cyc(input logic s);
    bus.strobe = s;
    @(posedge clk);
    #1;
    bus.strobe = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] p);
    bus.period = p;
    bus.start  = 1'b1;
    cyc(1'b0);
    bus.start  = 1'b0;
  endtask

  task automatic idle3();
    cyc(1'b0); cyc(1'b0); cyc(1'b0);
  endtask

  initial begin
    bus.strobe = 1'b0; bus.start = 1'b0; bus.period = '0;
    bus.pause = 1'b0; bus.abort = 1'b0; bus.repeat_en = 1'b0;

    #12;
    check("rst_count",   bus.count,   0);
    check("rst_running", bus.running, 0);
    check("rst_paused",  bus.paused,  0);
    check("rst_expired", bus.expired, 0);
    rst = 1'b1;
    cyc(1'b0);

    // Load and count down, strobe every 4 clocks
    do_start(8'd3);
    check("ld_running", bus.running, 1);
    check("ld_count",   bus.count,   3);
    idle3(); cyc(1'b1);
    check("dn_count2", bus.count, 2);
    check("dn_exp2",   bus.expired, 0);
    idle3(); cyc(1'b1);
    check("dn_count1", bus.count, 1);
    idle3(); cyc(1'b1);
    check("dn_count0",  bus.count,   0);
    check("dn_expired", bus.expired, 1);
    check("dn_running", bus.running, 0);
    cyc(1'b0);
    check("dn_exp_drop", bus.expired, 0);

    // Pause: count holds at 3, release strobe swallowed
    do_start(8'd5);
    cyc(1'b1); cyc(1'b1);
    check("pz_count_pre", bus.count, 3);
    bus.pause = 1'b1;
    cyc(1'b0);
    check("pz_paused",  bus.paused,  1);
    check("pz_running", bus.running, 1);
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    check("pz_hold", bus.count, 3);
    check("pz_paused_hold", bus.paused, 1);
    bus.pause = 1'b0;
    cyc(1'b1);
    check("pz_release_count",  bus.count,  3);
    check("pz_release_paused", bus.paused, 0);
    cyc(1'b1);
    check("pz_c2", bus.count, 2);
    cyc(1'b1);
    check("pz_c1", bus.count, 1);
    check("pz_e1", bus.expired, 0);
    cyc(1'b1);
    check("pz_c0", bus.count, 0);
    check("pz_expired", bus.expired, 1);
    cyc(1'b0);
    check("pz_exp_drop", bus.expired, 0);

    // Abort together with strobe
    do_start(8'd4);
    cyc(1'b1);
    check("ab_pre", bus.count, 3);
    bus.abort = 1'b1;
    cyc(1'b1);
    bus.abort = 1'b0;
    check("ab_count",   bus.count,   0);
    check("ab_running", bus.running, 0);
    check("ab_expired", bus.expired, 0);
    cyc(1'b1);
    check("ab_expired_after", bus.expired, 0);

    // Pause in IDLE is ignored
    bus.pause = 1'b1;
    cyc(1'b1);
    bus.pause = 1'b0;
    check("idle_pause", bus.paused, 0);

    // Zero period from IDLE, even with repeat enabled
    bus.repeat_en = 1'b1;
    do_start(8'd0);
    check("z_expired", bus.expired, 1);
    check("z_running", bus.running, 0);
    cyc(1'b0);
    check("z_drop", bus.expired, 0);

    // Repeat, period 2, strobe every cycle
    do_start(8'd2);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b1);
      check($sformatf("rp_count_%0d", k),   bus.count,   (k % 2 == 1) ? 1 : 2);
      check($sformatf("rp_expired_%0d", k), bus.expired, (k % 2 == 0) ? 1 : 0);
      check($sformatf("rp_running_%0d", k), bus.running, 1);
    end

    // Restart while running at count 2, then ignore period changes
    bus.repeat_en = 1'b0;
    do_start(8'd9);
    check("rs_count", bus.count, 9);
    bus.period = 8'd100;
    cyc(1'b1);
    check("rs_period_ignored", bus.count, 8);

    // Zero-period restart from RUN goes idle with a pulse
    do_start(8'd0);
    check("rz_expired", bus.expired, 1);
    check("rz_running", bus.running, 0);
    check("rz_count",   bus.count,   0);

    // Back-to-back expiries with period 1
    bus.repeat_en = 1'b1;
    do_start(8'd1);
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b1);
      check($sformatf("bb_expired_%0d", k), bus.expired, 1);
      check($sformatf("bb_count_%0d", k),   bus.count,   1);
    end
    bus.repeat_en = 1'b0;
    cyc(1'b1);
    check("bb_last_expired", bus.expired, 1);
    check("bb_last_running", bus.running, 0);

    // Maximum period
    do_start(8'd255);
    check("max_count", bus.count, 255);
    cyc(1'b1);
    check("max_dec", bus.count, 254);

    // Asynchronous reset mid-run
    do_start(8'd7);
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    check("mr_pre", bus.count, 4);
    #2;
    rst = 1'b0;
    #1;
    check("mr_count",   bus.count,   0);
    check("mr_running", bus.running, 0);
    check("mr_expired", bus.expired, 0);
    cyc(1'b1);
    rst = 1'b1;
    cyc(1'b1);
    check("mr_post_expired", bus.expired, 0);
    check("mr_post_running", bus.running, 0);
    cyc(1'b1);
    check("mr_post_count", bus.count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
